// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, load, logical shift, rotate and clear,
// with a wrapping shift counter that pulses done once per full word shifted.
module univ_shift_reg #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHR  = 3'b010,
    M_SHL  = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_CLR  = 3'b110,
    M_RSVD = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mode_e mode_sel;
  logic  counting;

  assign mode_sel = mode_e'(mode);
  assign counting = (mode_sel == M_SHR) || (mode_sel == M_SHL) ||
                    (mode_sel == M_ROR) || (mode_sel == M_ROL);

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        case (mode_sel)
          M_LOAD: begin
            q   <= d;
            cnt <= '0;
          end
          M_SHR:   q <= {sin_l, q[WIDTH-1:1]};
          M_SHL:   q <= {q[WIDTH-2:0], sin_r};
          M_ROR:   q <= {q[0], q[WIDTH-1:1]};
          M_ROL:   q <= {q[WIDTH-2:0], q[WIDTH-1]};
          M_CLR: begin
            q   <= '0;
            cnt <= '0;
          end
          default: q <= q;
        endcase
        // Counter wraps at WIDTH so a continuous stream pulses done every word
        if (counting) begin
          if (cnt == CNT_LAST) begin
            cnt  <= '0;
            done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: WIDTH=4 and WIDTH=8 instances driven with directed
// and random stimulus; an arithmetic reference model feeds per-instance expected queues.
module tb_univ_shift_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n4, en4, sl4, sr4, sout_r4, sout_l4, done4;
  logic [2:0] mode4;
  logic [3:0] d4, qo4;
  logic [2:0] cnt4;

  logic       rst_n8, en8, sl8, sr8, sout_r8, sout_l8, done8;
  logic [2:0] mode8;
  logic [7:0] d8, qo8;
  logic [3:0] cnt8;

  univ_shift_reg #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .en(en4), .mode(mode4), .d(d4), .sin_l(sl4), .sin_r(sr4),
    .q(qo4), .sout_r(sout_r4), .sout_l(sout_l4), .cnt(cnt4), .done(done4)
  );

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .en(en8), .mode(mode8), .d(d8), .sin_l(sl8), .sin_r(sr8),
    .q(qo8), .sout_r(sout_r8), .sout_l(sout_l8), .cnt(cnt8), .done(done8)
  );

  typedef struct {
    logic [63:0] q;
    int          cnt;
    bit          done;
  } exp_t;

  typedef struct {
    bit          rst_n;
    bit          en;
    bit [2:0]    mode;
    logic [63:0] d;
    bit          sl;
    bit          sr;
  } stim_t;

  exp_t        sb4[$], sb8[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] m4_q = '0, m8_q = '0;
  int          m4_cnt = 0, m8_cnt = 0;

  // Reference: word-level arithmetic on an unsigned value, count kept modulo w
  function automatic exp_t model(input int w, input logic [63:0] cur_q, input int cur_cnt,
                                 input stim_t s);
    exp_t        r;
    logic [63:0] mask;
    bit          counting;
    mask     = (64'd1 << w) - 64'd1;
    counting = 1'b0;
    r.q      = cur_q;
    r.cnt    = cur_cnt;
    r.done   = 1'b0;
    if (!s.rst_n) begin
      r.q   = '0;
      r.cnt = 0;
      return r;
    end
    if (!s.en) return r;
    case (s.mode)
      3'd1: begin r.q = s.d & mask; r.cnt = 0; end
      3'd2: begin r.q = (cur_q >> 1) | (64'(s.sl) << (w - 1)); counting = 1'b1; end
      3'd3: begin r.q = ((cur_q << 1) | 64'(s.sr)) & mask; counting = 1'b1; end
      3'd4: begin r.q = (cur_q >> 1) | ((cur_q & 64'd1) << (w - 1)); counting = 1'b1; end
      3'd5: begin r.q = ((cur_q << 1) & mask) | (cur_q >> (w - 1)); counting = 1'b1; end
      3'd6: begin r.q = '0; r.cnt = 0; end
      default: ;
    endcase
    if (counting) begin
      r.cnt  = (cur_cnt + 1) % w;
      r.done = (r.cnt == 0);
    end
    return r;
  endfunction

  function automatic stim_t mk(input bit r, input bit e, input bit [2:0] m,
                               input logic [63:0] dv, input bit sl = 1'b0, input bit sr = 1'b0);
    stim_t s;
    s.rst_n = r; s.en = e; s.mode = m; s.d = dv; s.sl = sl; s.sr = sr;
    return s;
  endfunction

  stim_t idle;

  task automatic drive(input stim_t a, input stim_t b);
    exp_t e;
    rst_n4 = a.rst_n; en4 = a.en; mode4 = a.mode; d4 = a.d[3:0]; sl4 = a.sl; sr4 = a.sr;
    rst_n8 = b.rst_n; en8 = b.en; mode8 = b.mode; d8 = b.d[7:0]; sl8 = b.sl; sr8 = b.sr;
    e = model(4, m4_q, m4_cnt, a); m4_q = e.q; m4_cnt = e.cnt; sb4.push_back(e);
    e = model(8, m8_q, m8_cnt, b); m8_q = e.q; m8_cnt = e.cnt; sb8.push_back(e);
    @(negedge clk);
  endtask

  task automatic op4(input stim_t a);
    drive(a, idle);
  endtask

  task automatic op8(input stim_t b);
    drive(idle, b);
  endtask

  task automatic check(input string name, input int w, input exp_t e, input logic [63:0] aq,
                       input logic [63:0] acnt, input logic adone, input logic asr,
                       input logic asl);
    logic esr, esl;
    esr = e.q[0];
    esl = e.q[w-1];
    n_vec++;
    if (aq !== e.q || acnt !== 64'(e.cnt) || adone !== e.done || asr !== esr || asl !== esl) begin
      n_bad++;
      $display("FAIL %s @%0t: got q=%h cnt=%0d done=%b sout_r=%b sout_l=%b, expected q=%h cnt=%0d done=%b sout_r=%b sout_l=%b",
               name, $time, aq, acnt, adone, asr, asl, e.q, e.cnt, e.done, esr, esl);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      check("w4", 4, e, 64'(qo4), 64'(cnt4), done4, sout_r4, sout_l4);
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb8.size() > 0) begin
      e = sb8.pop_front();
      check("w8", 8, e, 64'(qo8), 64'(cnt8), done8, sout_r8, sout_l8);
    end
  end

  initial begin
    idle = mk(1'b1, 1'b0, 3'd0, '0);
    rst_n4 = 1'b1; en4 = 1'b0; mode4 = '0; d4 = '0; sl4 = 1'b0; sr4 = 1'b0;
    rst_n8 = 1'b1; en8 = 1'b0; mode8 = '0; d8 = '0; sl8 = 1'b0; sr8 = 1'b0;
    @(negedge clk);

    // reset beats an enabled load
    repeat (2) drive(mk(0, 1, 3'd1, 64'hF), mk(0, 1, 3'd1, 64'hFF));
    op4(mk(1, 1, 3'd1, 64'hF));

    // serialize 1011 out of sout_r
    op4(mk(1, 1, 3'd1, 64'b1011));
    repeat (4) op4(mk(1, 1, 3'd2, '0, 1'b0));
    op4(mk(1, 1, 3'd0, '0));

    // shift-left then rotate both ways
    op4(mk(1, 1, 3'd1, 64'b0001));
    op4(mk(1, 1, 3'd3, '0, 1'b0, 1'b1));
    repeat (3) op4(mk(1, 1, 3'd5, '0));
    repeat (4) op4(mk(1, 1, 3'd4, '0));
    op4(mk(1, 1, 3'd0, '0));

    // enable low and reserved mode freeze state mid-word
    op4(mk(1, 1, 3'd1, 64'h5));
    repeat (2) op4(mk(1, 1, 3'd2, '0, 1'b1));
    repeat (3) op4(mk(1, 0, 3'd2, '0, 1'b1));
    repeat (2) op4(mk(1, 1, 3'd7, '0));

    // load / clear colliding with the last count
    op4(mk(1, 1, 3'd1, '0));
    repeat (3) op4(mk(1, 1, 3'd2, '0, 1'b1));
    op4(mk(1, 1, 3'd1, 64'hA));
    repeat (3) op4(mk(1, 1, 3'd3, '0, 1'b0, 1'b1));
    op4(mk(1, 1, 3'd6, '0));
    op4(mk(1, 1, 3'd0, '0));

    // wide instance: full rotation, then reset mid-sequence
    op8(mk(1, 1, 3'd1, 64'h81));
    repeat (8) op8(mk(1, 1, 3'd4, '0));
    op8(mk(1, 1, 3'd0, '0));
    repeat (3) op8(mk(1, 1, 3'd4, '0));
    op8(mk(0, 1, 3'd4, '0));
    op8(mk(1, 1, 3'd0, '0));

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      stim_t a, b;
      a = mk($urandom_range(99) >= 3, $urandom_range(9) != 0, 3'($urandom_range(7)),
             64'($urandom), 1'($urandom), 1'($urandom));
      b = mk($urandom_range(99) >= 3, $urandom_range(9) != 0, 3'($urandom_range(7)),
             64'($urandom), 1'($urandom), 1'($urandom));
      drive(a, b);
    end

    repeat (3) @(negedge clk);
    n_vec++;
    if (sb4.size() != 0 || sb8.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d entries left in scoreboards, expected 0/0",
               sb4.size(), sb8.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
